// File: rtl/adder_pkg.sv
// Shared definitions for the byte-serial adder: FSM encoding and default operand width.
package adder_pkg;
  localparam int NBYTES_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/byte_serial_adder_cla8.sv
// 8-bit carry-lookahead adder cell, reused one byte per cycle by byte_serial_adder.
module CLA8Bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       carryIn,
  output logic       carryOut,
  output logic [7:0] Sum
);
  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [8:0] w_c;

  assign w_g = A & B;
  assign w_p = A ^ B;

  // Generate/propagate recurrence; flattens to lookahead terms in synthesis.
  always_comb begin
    w_c[0] = carryIn;
    for (int i = 0; i < 8; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
  end

  assign Sum      = w_p ^ w_c[7:0];
  assign carryOut = w_c[8];
endmodule

// File: rtl/byte_serial_adder.sv
// Adds two NBYTES-wide operands one byte per cycle through a single CLA8Bit.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid holds data stable until it does.
module byte_serial_adder
  import adder_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_a,
  input  logic [8*NBYTES-1:0]   in_b,
  input  logic                  in_cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_ovf,
  output state_t                dbg_state
);
  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t          r_state;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_cin;
  logic [IDXW-1:0] r_idx;
  logic            r_carry;
  logic [W-1:0]    r_acc;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;

  logic [7:0]      w_a_byte;
  logic [7:0]      w_b_byte;
  logic            w_cin;
  logic            w_cout;
  logic [7:0]      w_sum;
  logic [W-1:0]    w_result;
  logic            w_last;

  assign w_a_byte = r_a[{r_idx, 3'b000} +: 8];
  assign w_b_byte = r_b[{r_idx, 3'b000} +: 8];
  assign w_cin    = (r_idx == '0) ? r_cin : r_carry;
  assign w_last   = (r_idx == IDXW'(NBYTES - 1));

  CLA8Bit u_cla (
    .A        (w_a_byte),
    .B        (w_b_byte),
    .carryIn  (w_cin),
    .carryOut (w_cout),
    .Sum      (w_sum)
  );

  // Working accumulator with the current byte merged in; published only on DONE entry.
  always_comb begin
    w_result = r_acc;
    w_result[{r_idx, 3'b000} +: 8] = w_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_cin       <= 1'b0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_acc       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= in_a;
            r_b        <= in_b;
            r_cin      <= in_cin;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_acc      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_acc   <= w_result;
          r_carry <= w_cout;
          if (w_last) begin
            r_idx       <= '0;
            r_sum       <= w_result;
            r_cout      <= w_cout;
            r_ovf       <= (r_a[W-1] == r_b[W-1]) && (w_result[W-1] != r_a[W-1]);
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_byte_serial_adder.sv
// Scoreboard bench for byte_serial_adder: directed corner operands, stalls, mid-run reset, random ops.
module tb_byte_serial_adder;
  import adder_pkg::*;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  state_t       dbg_state;

  // expected entry: {cout, ovf, sum}
  logic [W+1:0] exp_q[$];
  int           total;
  int           bad;

  byte_serial_adder #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    logic [W:0] s;
    logic       ovf;
    s   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return {s[W], ovf, s[W-1:0]};
  endfunction

  // driver: called at a negedge; offers the op so the next posedge accepts it
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    if (push) exp_q.push_back(model(a, b, cin));
  endtask

  // waits for result, optionally stalls with junk on the input side, then pops and compares
  task automatic wait_result(input int stall, input bit junk);
    int           lat;
    logic [W+1:0] e;
    logic [W-1:0] s0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (junk) begin
        in_valid = 1'b1;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_cin   = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
    end while (!out_valid && lat < 50);
    chk("latency", 64'(lat), 64'(NBYTES + 1));
    if (exp_q.size() == 0) begin
      chk("queue_empty", 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    s0 = out_sum;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (junk) begin
        in_valid = 1'b1;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_cin   = 1'($urandom_range(0, 1));
      end
      chk("stall_sum_stable", 64'(out_sum), 64'(s0));
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
    end
    chk("sum", 64'(out_sum), 64'(e[W-1:0]));
    chk("cout", 64'(out_cout), 64'(e[W+1]));
    chk("ovf", 64'(out_ovf), 64'(e[W]));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("post_hs_out_valid", 64'(out_valid), 64'd0);
    chk("post_hs_in_ready", 64'(in_ready), 64'd1);
    chk("post_hs_sum_persist", 64'(out_sum), 64'(e[W-1:0]));
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(out_sum), 64'd0);
    chk("rst_cout", 64'(out_cout), 64'd0);
    chk("rst_ovf", 64'(out_ovf), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));

    // directed corner operands with hand-derived expectations
    launch(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1);
    wait_result(0, 1'b0);
    chk("d1_sum", 64'(out_sum), 64'h0000_0002);
    launch(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1);
    wait_result(0, 1'b0);
    chk("d2_sum", 64'(out_sum), 64'h0000_0100);
    launch(32'h001B_00FF, 32'h00D7_0001, 1'b1, 1'b1);
    wait_result(0, 1'b1);
    chk("d3_sum", 64'(out_sum), 64'h00F2_0101);
    launch(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
    wait_result(0, 1'b0);
    chk("d4_sum", 64'(out_sum), 64'h0000_0000);
    chk("d4_cout", 64'(out_cout), 64'd1);
    chk("d4_ovf", 64'(out_ovf), 64'd0);
    launch(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    wait_result(0, 1'b0);
    chk("d5_sum", 64'(out_sum), 64'h8000_0000);
    chk("d5_cout", 64'(out_cout), 64'd0);
    chk("d5_ovf", 64'(out_ovf), 64'd1);

    // stall in DONE with busy input side, then back-to-back op right after the handshake
    launch(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b1);
    wait_result(5, 1'b1);
    launch(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
    wait_result(0, 1'b0);
    chk("neg_ovf", 64'(out_ovf), 64'd1);

    // reset while byte 2 is in flight
    launch(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_sum_cleared", 64'(out_sum), 64'd0);
    launch(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b1);
    wait_result(0, 1'b0);
    chk("after_rst_sum", 64'(out_sum), 64'h0000_0007);

    // random ops with random stalls
    for (int k = 0; k < 12; k++) begin
      launch(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      wait_result($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
